// File: rtl/lzc_pattern_gen.sv
// Frame generator driving an LZC input: emits `word` beats whose MSB-first
// leading-zero count equals the clamped target, followed by LFSR filler bits.
module lzc_pattern_gen #(
  parameter int          width    = 8,
  parameter int          word     = 32,
  parameter logic [15:0] DEF_SEED = 16'hACE1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [8:0]       i_target,
  input  logic             i_mode_in,
  input  logic [15:0]      i_seed,
  input  logic             i_stall,
  output logic             o_mode,
  output logic             o_ivalid,
  output logic [width-1:0] o_data,
  output logic             o_busy,
  output logic             o_done,
  output logic [8:0]       o_exp_zeros
);

  localparam int            KW     = (word > 1) ? $clog2(word) : 1;
  localparam logic [8:0]    TOTAL  = 9'(width * word);
  localparam logic [KW-1:0] K_LAST = KW'(word - 1);

  typedef enum logic [1:0] {IDLE, SEND, FIN} state_t;

  state_t            r_state, w_state_next;
  logic [KW-1:0]     r_k, w_k_next;
  logic [15:0]       r_lfsr, w_lfsr_next;
  logic [8:0]        r_t, w_t_next;
  logic              r_mode_lat, w_mode_lat_next;
  logic              r_last, w_last_next;

  logic              r_mode, w_mode_next;
  logic              r_ivalid, w_ivalid_next;
  logic [width-1:0]  r_data, w_data_next;
  logic              r_busy, w_busy_next;
  logic              r_done, w_done_next;
  logic [8:0]        r_exp_zeros, w_exp_zeros_next;

  logic [15:0]       w_seed_eff;
  logic [8:0]        w_t_clamp;
  logic [KW-1:0]     w_src_k;
  logic [8:0]        w_src_t;
  logic [15:0]       w_src_lfsr;
  logic [15:0]       w_lfsr_step;
  logic [8:0]        w_base;
  logic [width-1:0]  w_beat;
  logic              w_emit_slot;

  assign w_seed_eff = (i_seed == 16'h0000) ? DEF_SEED : i_seed;
  assign w_t_clamp  = (i_target > TOTAL) ? TOTAL : i_target;

  // On the accepting edge the first beat is built straight from the inputs.
  assign w_src_k    = (r_state == IDLE) ? '0         : r_k;
  assign w_src_t    = (r_state == IDLE) ? w_t_clamp  : r_t;
  assign w_src_lfsr = (r_state == IDLE) ? w_seed_eff : r_lfsr;

  assign w_lfsr_step = {1'b0, w_src_lfsr[15:1]} ^ (w_src_lfsr[0] ? 16'hB400 : 16'h0000);
  assign w_base      = 9'(32'(w_src_k) * width);

  generate
    for (genvar gi = 0; gi < width; gi++) begin : g_bit
      localparam logic [8:0] OFF = 9'(width - 1 - gi);
      logic [8:0] w_pos;
      assign w_pos = w_base + OFF;
      assign w_beat[gi] = (w_pos < w_src_t) ? 1'b0 :
                          (w_pos == w_src_t) ? 1'b1 : w_src_lfsr[gi];
    end
  endgenerate

  always_comb begin
    w_state_next     = r_state;
    w_k_next         = r_k;
    w_lfsr_next      = r_lfsr;
    w_t_next         = r_t;
    w_mode_lat_next  = r_mode_lat;
    w_last_next      = r_last;
    w_ivalid_next    = 1'b0;
    w_data_next      = '0;
    w_done_next      = 1'b0;
    w_exp_zeros_next = r_exp_zeros;
    w_emit_slot      = 1'b0;

    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_state_next    = SEND;
          w_t_next        = w_t_clamp;
          w_mode_lat_next = i_mode_in;
          w_k_next        = '0;
          w_lfsr_next     = w_seed_eff;
          w_last_next     = 1'b0;
          w_emit_slot     = 1'b1;
        end
      end
      SEND: begin
        if (r_last) begin
          w_state_next     = FIN;
          w_done_next      = 1'b1;
          w_exp_zeros_next = r_t;
        end else begin
          w_emit_slot = 1'b1;
        end
      end
      FIN:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase

    // A stalled slot leaves k and the LFSR untouched and drives a zero bubble.
    if (w_emit_slot && !i_stall) begin
      w_ivalid_next = 1'b1;
      w_data_next   = w_beat;
      w_k_next      = w_src_k + 1'b1;
      w_lfsr_next   = w_lfsr_step;
      w_last_next   = (w_src_k == K_LAST);
    end

    w_busy_next = (w_state_next != IDLE);
    w_mode_next = (w_state_next != IDLE) ? w_mode_lat_next : 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_k         <= '0;
      r_lfsr      <= DEF_SEED;
      r_t         <= '0;
      r_mode_lat  <= 1'b0;
      r_last      <= 1'b0;
      r_mode      <= 1'b0;
      r_ivalid    <= 1'b0;
      r_data      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_exp_zeros <= '0;
    end else begin
      r_state     <= w_state_next;
      r_k         <= w_k_next;
      r_lfsr      <= w_lfsr_next;
      r_t         <= w_t_next;
      r_mode_lat  <= w_mode_lat_next;
      r_last      <= w_last_next;
      r_mode      <= w_mode_next;
      r_ivalid    <= w_ivalid_next;
      r_data      <= w_data_next;
      r_busy      <= w_busy_next;
      r_done      <= w_done_next;
      r_exp_zeros <= w_exp_zeros_next;
    end
  end

  assign o_mode      = r_mode;
  assign o_ivalid    = r_ivalid;
  assign o_data      = r_data;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_exp_zeros = r_exp_zeros;

endmodule

// File: tb/tb_lzc_pattern_gen.sv
// Scoreboard bench for lzc_pattern_gen: a frame-level model queues expected
// beats and end-of-frame results; a negedge monitor pops and compares them.
module tb_lzc_pattern_gen;
  localparam int W = 8;
  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_start = 1'b0;
  logic [8:0]   i_target = '0;
  logic         i_mode_in = 1'b0;
  logic [15:0]  i_seed = '0;
  logic         i_stall = 1'b0;
  logic         o_mode, o_ivalid, o_busy, o_done;
  logic [W-1:0] o_data;
  logic [8:0]   o_exp_zeros;

  int checks = 0;
  int failures = 0;

  typedef struct { logic mode; logic [W-1:0] data; } beat_t;
  typedef struct { int zeros; logic mode; } done_t;
  beat_t exp_beats[$];
  done_t exp_done[$];

  lzc_pattern_gen #(.width(W), .word(N), .DEF_SEED(16'hACE1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_target(i_target),
    .i_mode_in(i_mode_in), .i_seed(i_seed), .i_stall(i_stall),
    .o_mode(o_mode), .o_ivalid(o_ivalid), .o_data(o_data), .o_busy(o_busy),
    .o_done(o_done), .o_exp_zeros(o_exp_zeros)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Whole frame as a flat bit string: zeros up to T, a one at T, LFSR filler after.
  task automatic push_frame(input int tgt, input logic [15:0] seed, input logic mode);
    int t;
    logic [15:0] l;
    beat_t b;
    done_t d;
    t = (tgt > W * N) ? W * N : tgt;
    l = (seed == 16'h0) ? 16'hACE1 : seed;
    for (int k = 0; k < N; k++) begin
      b.mode = mode;
      for (int i = 0; i < W; i++) begin
        int p;
        p = k * W + (W - 1 - i);
        b.data[i] = (p < t) ? 1'b0 : (p == t) ? 1'b1 : l[i];
      end
      exp_beats.push_back(b);
      l = (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
    end
    d.zeros = t;
    d.mode  = mode;
    exp_done.push_back(d);
  endtask

  // Monitor: independent LZC over the received beats plus queue comparison.
  int mon_lz = 0;
  bit mon_found = 0;
  always @(negedge clk) begin
    beat_t b;
    done_t d;
    if (!rst_n) begin
      mon_lz = 0;
      mon_found = 0;
    end else begin
      if (o_ivalid) begin
        if (exp_beats.size() == 0) chk("unexpected_beat", 1, 0);
        else begin
          b = exp_beats.pop_front();
          chk("beat_data", int'(o_data), int'(b.data));
          chk("beat_mode", int'(o_mode), int'(b.mode));
        end
        for (int i = W - 1; i >= 0; i--) begin
          if (!mon_found) begin
            if (o_data[i]) mon_found = 1;
            else mon_lz++;
          end
        end
      end else if (o_busy && !o_done) begin
        chk("bubble_data", int'(o_data), 0);
      end
      if (o_done) begin
        chk("done_ivalid", int'(o_ivalid), 0);
        if (exp_done.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          d = exp_done.pop_front();
          chk("exp_zeros", int'(o_exp_zeros), d.zeros);
          chk("lzc_of_frame", mon_lz, d.zeros);
          chk("fin_mode", int'(o_mode), int'(d.mode));
        end
        mon_lz = 0;
        mon_found = 0;
      end
      if (!o_busy) chk("idle_quiet", int'({o_mode, o_ivalid, o_done}), 0);
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_ivalid"}, int'(o_ivalid), 0);
    chk({tag, "_data"}, int'(o_data), 0);
    chk({tag, "_busy"}, int'(o_busy), 0);
    chk({tag, "_done"}, int'(o_done), 0);
    chk({tag, "_mode"}, int'(o_mode), 0);
    chk({tag, "_expz"}, int'(o_exp_zeros), 0);
  endtask

  task automatic run_frame(input int tgt, input logic [15:0] seed, input logic mode,
                           input logic [63:0] stall_pat, input bit busy_start,
                           input bit fin_start, input int abort_cycle);
    int cyc, nst, bubbles;
    bit got, aborted;
    @(negedge clk);
    i_target = 9'(tgt); i_seed = seed; i_mode_in = mode;
    i_start = 1'b1; i_stall = stall_pat[0];
    push_frame(tgt, seed, mode);
    nst = $countones(stall_pat);
    cyc = 0; bubbles = 0; got = 0; aborted = 0;
    while (cyc < 200 && !got && !aborted) begin
      @(negedge clk);
      cyc++;
      i_start = 1'b0;
      i_stall = (cyc < 64) ? stall_pat[cyc] : 1'b0;
      if (busy_start && cyc == 10) begin i_start = 1'b1; i_target = 9'd5; end
      if (cyc == abort_cycle) begin
        #2 rst_n = 1'b0;
        #1 check_all_zero("abort");
        repeat (3) begin
          @(negedge clk);
          chk("abort_no_done", int'(o_done), 0);
        end
        exp_beats.delete();
        exp_done.delete();
        @(negedge clk);
        rst_n = 1'b1;
        aborted = 1;
      end else begin
        if (o_busy && !o_ivalid && !o_done) bubbles++;
        if (o_done) got = 1;
      end
    end
    if (!aborted) begin
      chk("done_seen", int'(got), 1);
      chk("done_cycle", cyc, N + 1 + nst);
      chk("bubble_count", bubbles, nst);
    end
    if (fin_start) begin
      i_start = 1'b1; i_target = 9'd7; i_seed = 16'h1234;
    end else begin
      i_start = 1'b0;
    end
    i_stall = 1'b0;
  endtask

  initial begin
    logic [63:0] pat;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("post_reset");

    run_frame(0, 16'h0001, 1'b1, 64'h0, 0, 0, -1);
    run_frame(13, 16'(($urandom)), 1'b0, 64'h0, 0, 0, -1);
    run_frame(300, 16'h5A5A, 1'b1, 64'h0, 0, 0, -1);
    run_frame(256, 16'h5A5A, 1'b1, 64'h0, 0, 0, -1);
    run_frame(40, 16'hBEEF, 1'b0, 64'h0, 0, 0, -1);
    run_frame(40, 16'hBEEF, 1'b0, 64'h1C00, 0, 0, -1);
    run_frame(20, 16'h0F0F, 1'b1, 64'h0, 1, 1, -1);
    run_frame(100, 16'h3333, 1'b0, 64'h0, 0, 0, -1);
    run_frame(77, 16'h4444, 1'b1, 64'h0, 0, 0, 11);
    run_frame(9, 16'h0000, 1'b1, 64'h0, 0, 0, -1);
    for (int n = 0; n < 8; n++) begin
      pat = 64'($urandom) & 64'h1F_FFFF;
      run_frame(int'($urandom_range(0, 300)), 16'($urandom), 1'($urandom_range(0, 1)),
                pat, 0, 0, -1);
    end

    repeat (3) @(negedge clk);
    chk("beats_left", exp_beats.size(), 0);
    chk("dones_left", exp_done.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=1 expected=0");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/lzc_pattern_gen.md
Name: lzc_pattern_gen

Overview:
- Transmit-side counterpart of the LZC block: a frame generator that drives the LZC input interface (MODE, IVALID, DATA).
- For a requested leading-zero count it emits a frame of `word` beats of `width` bits. The frame's leading-zero count, taken MSB-first across beats, is exactly the requested value. Bits after the first one are LFSR pseudo-random filler.
- Used as on-chip BIST source and bench stimulus for LZC. Reports the expected ZEROS value for a scoreboard.

Parameters:
- width, 8, bits per DATA beat; legal range 1..16.
- word, 32, beats per frame; width*word must be ≤ 511.
- DEF_SEED, 16'hACE1, LFSR seed substituted when SEED==0.

Ports:
- CLK  input  1  clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- START  input  1  frame request, sampled in IDLE only.
- TARGET  input  9  requested leading-zero count.
- MODE_IN  input  1  MODE value to drive for the whole frame.
- SEED  input  16  LFSR seed, latched on accepted START.
- STALL  input  1  insert a bubble on the next cycle.
- MODE  output  1  to LZC MODE.
- IVALID  output  1  to LZC IVALID.
- DATA  output  width  to LZC DATA.
- BUSY  output  1  frame in progress.
- DONE  output  1  one-cycle end-of-frame pulse.
- EXP_ZEROS  output  9  expected LZC result; valid while DONE=1.

Behaviour:
- All outputs are registered. While RST_N=0, every output is 0, state is IDLE, the beat counter is 0 and the LFSR equals DEF_SEED.
- FSM states: IDLE, SEND, FIN.
- IDLE → SEND when START=1 at a rising edge. On that edge:
  - T = min(TARGET, width*word) is latched.
  - MODE_IN and SEED are latched; SEED==0 is replaced by DEF_SEED.
  - The beat counter k is cleared.
- START is ignored in SEND and FIN.
- SEND output rules:
  - Each cycle drives IVALID=1 with beat k unless STALL was 1 at the previous edge. In that case IVALID=0, DATA=0, and k and the LFSR hold.
  - The first beat appears on the cycle after START is accepted, if STALL was 0 at that edge.
- Bit mapping for beat k:
  - Global position p = k*width + (width-1-i) for DATA[i]; p=0 is the MSB of beat 0.
  - DATA[i] = 0 if p < T.
  - DATA[i] = 1 if p == T.
  - DATA[i] = lfsr[i] if p > T.
- LFSR:
  - 16-bit Galois, taps x^16+x^14+x^13+x^11.
  - Advances one step per emitted beat (IVALID=1 cycle) only.
- MODE equals the latched MODE_IN throughout SEND and FIN, and is 0 in IDLE.
- SEND → FIN on the edge after beat word-1 is emitted.
- FIN lasts one cycle: DONE=1, EXP_ZEROS=T, IVALID=0. FIN → IDLE.
- EXP_ZEROS holds T until the next accepted START; it is 0 after reset.
- BUSY=1 in SEND and FIN.
- Boundary cases:
  - T=0 → DATA MSB of beat 0 is 1.
  - T=width*word → the all-zero frame with no 1 bit.
  - TARGET above the limit clamps to width*word.
  - START asserted on the FIN cycle is ignored.
  - START asserted the cycle after FIN (IDLE) is accepted, giving a minimum frame-to-frame gap of 2 cycles.
- Reset mid-frame: asynchronous abort. Outputs drop to 0 immediately and no DONE is issued.
- Counter width: k is ceil(log2(word)) bits. p is compared at 9 bits with no overflow, since width*word ≤ 511.

Test Plan:
- Defaults, TARGET=0, SEED=1, MODE_IN=1, STALL=0 → IVALID on cycles 1..32 after START, beat0 DATA[7]=1, MODE=1 throughout. DONE on cycle 33 with EXP_ZEROS=0. Behavioural LZC model returns 0.
- TARGET=13 → beat0=8'h00. Beat1 has DATA[7:3]=0 and DATA[2]=1, with DATA[1:0] equal to LFSR bits. Remaining beats are filler. EXP_ZEROS=13.
- TARGET=300 → all 32 beats are 8'h00 and EXP_ZEROS=256 (clamp). TARGET=256 gives the identical frame.
- STALL=1 for 3 cycles mid-frame → exactly 3 IVALID=0 bubbles with DATA=0. Beat content and LFSR sequence match the unstalled run. DONE is delayed by 3 cycles.
- START pulsed while BUSY with TARGET=5 → ignored; the current frame completes with its original T. START in the following IDLE cycle is accepted.
- RST_N=0 at beat 10 → all outputs 0 asynchronously, no DONE. After release, a new START with SEED=0 produces the DEF_SEED filler sequence.
